// File: rtl/wb_timer_mc_pkg.sv
// Shared register offsets, channel types and byte-lane helpers for wb_timer_mc.
`timescale 1ns/1ps
package wb_timer_mc_pkg;

  localparam logic [7:0] GCTRL_O    = 8'h00;
  localparam logic [7:0] PRESC_O    = 8'h04;
  localparam logic [7:0] IRQ_STAT_O = 8'h08;
  localparam logic [7:0] IRQ_EN_O   = 8'h0C;
  localparam logic [7:0] CH_BASE_O  = 8'h10;
  localparam logic [7:0] CH_STRIDE  = 8'h10;

  // Word index inside one channel's 16-byte slot
  localparam logic [1:0] CH_LOAD_R  = 2'd0;
  localparam logic [1:0] CH_COUNT_R = 2'd1;
  localparam logic [1:0] CH_CTRL_R  = 2'd2;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ARM,
    CH_RUN
  } ch_state_e;

  typedef struct packed {
    logic periodic;
    logic en;
  } ch_ctrl_t;

  function automatic logic [31:0] be_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  sel);
    return (old_v & ~be_mask(sel)) | (new_v & be_mask(sel));
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle, 32-bit data with byte selects.
`timescale 1ns/1ps
interface wb_if;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        stall;
  logic        err;

  modport slave (
    input  adr, dat_m, we, sel, stb, cyc,
    output dat_s, ack, stall, err
  );

  modport master (
    output adr, dat_m, we, sel, stb, cyc,
    input  dat_s, ack, stall, err
  );
endinterface

// File: rtl/wb_timer_mc_chan.sv
// One countdown channel: IDLE -> ARM -> RUN, one-shot or periodic, expiry pulse on tick at zero.
`timescale 1ns/1ps
module wb_timer_mc_chan
  import wb_timer_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_load_wr,
  input  logic             i_ctrl_wr,
  input  ch_ctrl_t         i_ctrl_wdata,
  input  logic [CNT_W-1:0] i_load_wdata,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_load,
  output ch_ctrl_t         o_ctrl,
  output logic             o_expire
);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_load;
  ch_ctrl_t         r_ctrl;
  ch_ctrl_t         w_ctrl_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CH_IDLE;
      r_count <= '0;
      r_load  <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ctrl  <= w_ctrl_nxt;
      if (i_load_wr) begin
        r_load <= i_load_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_ctrl_nxt  = r_ctrl;
    o_expire    = 1'b0;

    unique case (r_state)
      CH_IDLE: ;
      CH_ARM: begin
        w_count_nxt = r_load;
        w_state_nxt = CH_RUN;
      end
      CH_RUN: begin
        if (i_tick) begin
          if (r_count != '0) begin
            w_count_nxt = r_count - CNT_W'(1);
          end else begin
            o_expire = 1'b1;
            if (r_ctrl.periodic) begin
              w_count_nxt = r_load;
            end else begin
              w_ctrl_nxt.en = 1'b0;
              w_state_nxt   = CH_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = CH_IDLE;
    endcase

    // A control write overrides the state move but leaves any expiry/count update of this cycle intact
    if (i_ctrl_wr) begin
      w_ctrl_nxt  = i_ctrl_wdata;
      w_state_nxt = i_ctrl_wdata.en ? CH_ARM : CH_IDLE;
    end
  end

  assign o_count = r_count;
  assign o_load  = r_load;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/wb_timer_mc.sv
// Multi-channel Wishbone timer: bus decode, shared prescaler, IRQ status/enable and read mux.
`timescale 1ns/1ps
module wb_timer_mc
  import wb_timer_mc_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  wb_if.slave               wb,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_ch
);

  localparam logic [7:0] CH_SPAN = 8'(CH_STRIDE * NUM_CH);

  logic               w_req;
  logic               w_wr;
  logic [7:0]         w_off;
  logic [7:0]         w_ch_rel;
  logic [2:0]         w_ch_idx;
  logic [1:0]         w_ch_reg;
  logic               w_ch_hit;
  logic [31:0]        w_rdata;
  logic               w_tick;
  logic               w_presc_wr;
  logic [NUM_CH-1:0]  w_stat_clr;
  logic [NUM_CH-1:0]  w_expire;
  logic [NUM_CH-1:0]  w_load_wr;
  logic [NUM_CH-1:0]  w_ctrl_wr;
  logic [CNT_W-1:0]   w_count      [NUM_CH];
  logic [CNT_W-1:0]   w_load       [NUM_CH];
  logic [CNT_W-1:0]   w_load_wdata [NUM_CH];
  ch_ctrl_t           w_ctrl       [NUM_CH];
  logic               w_unused;

  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_gen;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [NUM_CH-1:0]  r_stat;
  logic [NUM_CH-1:0]  r_en;
  logic [NUM_CH-1:0]  r_irq_ch;
  logic               r_irq;

  assign w_req    = wb.stb & wb.cyc;
  assign w_wr     = w_req & wb.we;
  assign w_off    = {wb.adr[7:2], 2'b00};
  assign w_ch_rel = w_off - CH_BASE_O;
  assign w_ch_idx = w_ch_rel[6:4];
  assign w_ch_reg = w_ch_rel[3:2];
  assign w_ch_hit = (w_off >= CH_BASE_O) && (w_ch_rel < CH_SPAN);
  assign w_unused = ^{wb.adr[31:8], wb.adr[1:0], w_ch_rel[7], w_ch_rel[1:0]};

  assign w_presc_wr = w_wr && (w_off == PRESC_O);
  assign w_stat_clr = (w_wr && (w_off == IRQ_STAT_O))
                      ? NUM_CH'(wb.dat_m & be_mask(wb.sel)) : '0;
  assign w_tick     = r_gen && (r_presc_cnt == r_presc);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_sel_ch;
    assign w_sel_ch        = w_wr && w_ch_hit && (w_ch_idx == 3'(i));
    assign w_load_wr[i]    = w_sel_ch && (w_ch_reg == CH_LOAD_R);
    assign w_ctrl_wr[i]    = w_sel_ch && (w_ch_reg == CH_CTRL_R) && wb.sel[0];
    assign w_load_wdata[i] = CNT_W'(be_merge(32'(w_load[i]), wb.dat_m, wb.sel));

    wb_timer_mc_chan #(.CNT_W(CNT_W)) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_tick       (w_tick),
      .i_load_wr    (w_load_wr[i]),
      .i_ctrl_wr    (w_ctrl_wr[i]),
      .i_ctrl_wdata (ch_ctrl_t'(wb.dat_m[1:0])),
      .i_load_wdata (w_load_wdata[i]),
      .o_count      (w_count[i]),
      .o_load       (w_load[i]),
      .o_ctrl       (w_ctrl[i]),
      .o_expire     (w_expire[i])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_ch_hit) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_ch_idx == 3'(c)) begin
          unique case (w_ch_reg)
            CH_LOAD_R:  w_rdata = 32'(w_load[c]);
            CH_COUNT_R: w_rdata = 32'(w_count[c]);
            CH_CTRL_R:  w_rdata = 32'(w_ctrl[c]);
            default:    w_rdata = '0;
          endcase
        end
      end
    end else begin
      unique case (w_off)
        GCTRL_O:    w_rdata = 32'(r_gen);
        PRESC_O:    w_rdata = 32'(r_presc);
        IRQ_STAT_O: w_rdata = 32'(r_stat);
        IRQ_EN_O:   w_rdata = 32'(r_en);
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_gen       <= 1'b0;
      r_presc     <= '0;
      r_presc_cnt <= '0;
      r_stat      <= '0;
      r_en        <= '0;
      r_irq_ch    <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wb.we) ? w_rdata : '0;

      if (!r_gen || w_presc_wr || w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end

      // Expiry is OR-ed in after the clear so a same-cycle set wins
      r_stat   <= (r_stat & ~w_stat_clr) | w_expire;
      r_irq_ch <= r_stat & r_en;
      r_irq    <= |(r_stat & r_en);

      if (w_wr && (w_off == GCTRL_O) && wb.sel[0]) begin
        r_gen <= wb.dat_m[0];
      end
      if (w_presc_wr) begin
        r_presc <= PRESC_W'(be_merge(32'(r_presc), wb.dat_m, wb.sel));
      end
      if (w_wr && (w_off == IRQ_EN_O)) begin
        r_en <= NUM_CH'(be_merge(32'(r_en), wb.dat_m, wb.sel));
      end
    end
  end

  assign wb.ack   = r_ack;
  assign wb.dat_s = r_dat;
  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;
  assign irq      = r_irq;
  assign irq_ch   = r_irq_ch;

endmodule

// File: tb/tb_wb_timer_mc.sv
// Bench for wb_timer_mc: directed scenarios plus random bus traffic against a behavioural model.
`timescale 1ns/1ps
module tb_wb_timer_mc;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CW    = 12;
  localparam int unsigned PW    = 8;
  localparam logic [31:0] CMASK = 32'h0000_0FFF;
  localparam logic [31:0] PMASK = 32'h0000_00FF;
  localparam logic [31:0] NMASK = 32'h0000_000F;

  logic           clk = 1'b0;
  logic           rst;
  logic           irq;
  logic [NCH-1:0] irq_ch;

  wb_if wb_bus ();

  wb_timer_mc #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .wb     (wb_bus),
    .irq    (irq),
    .irq_ch (irq_ch)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc_no   = 0;

  // Behavioural model state
  bit          m_gen, m_ack, m_rdv, m_irq;
  logic [31:0] m_presc, m_pcnt, m_stat, m_en, m_irq_ch, m_dat;
  logic [31:0] m_load [NCH];
  logic [31:0] m_cnt  [NCH];
  bit          m_chen [NCH];
  bit          m_per  [NCH];
  bit          m_pend [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_gen = 0; m_ack = 0; m_rdv = 0; m_irq = 0;
    m_presc = 0; m_pcnt = 0; m_stat = 0; m_en = 0; m_irq_ch = 0; m_dat = 0;
    for (int c = 0; c < NCH; c++) begin
      m_load[c] = 0; m_cnt[c] = 0; m_chen[c] = 0; m_per[c] = 0; m_pend[c] = 0;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    int o;
    int c;
    o = int'(off);
    if (o == 'h00) return {31'd0, m_gen};
    if (o == 'h04) return m_presc;
    if (o == 'h08) return m_stat;
    if (o == 'h0C) return m_en;
    if (o >= 16 && o < 16 + 16 * NCH) begin
      c = (o - 16) / 16;
      case (o % 16)
        0:       return m_load[c];
        4:       return m_cnt[c];
        8:       return {30'd0, m_per[c], m_chen[c]};
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  // One clock edge of the timer as the register map describes it, using the inputs present at that edge
  function automatic void m_update();
    logic [31:0] bm, wd, clr, expv, pcnt_n;
    logic [7:0]  off;
    bit          req, wr, tick, presc_wr;
    int          o, c;
    if (rst) begin
      m_reset();
      return;
    end
    req = wb_bus.stb && wb_bus.cyc;
    wr  = req && wb_bus.we;
    off = {wb_bus.adr[7:2], 2'b00};
    o   = int'(off);
    wd  = wb_bus.dat_m;
    bm  = {{8{wb_bus.sel[3]}}, {8{wb_bus.sel[2]}}, {8{wb_bus.sel[1]}}, {8{wb_bus.sel[0]}}};

    m_ack    = req;
    m_rdv    = req && !wb_bus.we;
    m_dat    = m_rdv ? m_read(off) : 32'd0;
    m_irq_ch = m_stat & m_en;
    m_irq    = (m_irq_ch != 0);

    tick     = m_gen && (m_pcnt == m_presc);
    presc_wr = wr && (o == 'h04);
    pcnt_n   = (!m_gen || presc_wr || tick) ? 32'd0 : m_pcnt + 1;

    expv = 0;
    for (int k = 0; k < NCH; k++) begin
      if (m_chen[k]) begin
        if (m_pend[k]) begin
          m_cnt[k]  = m_load[k];
          m_pend[k] = 0;
        end else if (tick) begin
          if (m_cnt[k] != 0) m_cnt[k] = m_cnt[k] - 1;
          else begin
            expv[k] = 1'b1;
            if (m_per[k]) m_cnt[k] = m_load[k];
            else m_chen[k] = 0;
          end
        end
      end
    end

    clr    = (wr && o == 'h08) ? (wd & bm & NMASK) : 32'd0;
    m_stat = (m_stat & ~clr) | expv;
    m_pcnt = pcnt_n;

    if (wr) begin
      if (o == 'h00 && wb_bus.sel[0]) m_gen = wd[0];
      if (presc_wr) m_presc = ((m_presc & ~bm) | (wd & bm)) & PMASK;
      if (o == 'h0C) m_en = ((m_en & ~bm) | (wd & bm)) & NMASK;
      if (o >= 16 && o < 16 + 16 * NCH) begin
        c = (o - 16) / 16;
        if (o % 16 == 0) m_load[c] = ((m_load[c] & ~bm) | (wd & bm)) & CMASK;
        if (o % 16 == 8 && wb_bus.sel[0]) begin
          m_per[c]  = wd[1];
          m_chen[c] = wd[0];
          m_pend[c] = wd[0];
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    m_update();
    cyc_no++;
    @(negedge clk);
    check("ack", 32'(wb_bus.ack), 32'(m_ack));
    if (m_rdv) check("dat_s", wb_bus.dat_s, m_dat);
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_ch", 32'(irq_ch), m_irq_ch);
    check("stall_err", 32'({wb_bus.stall, wb_bus.err}), 32'd0);
  endtask

  task automatic drive(input bit we, input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
    wb_bus.cyc   = 1'b1;
    wb_bus.stb   = 1'b1;
    wb_bus.we    = we;
    wb_bus.adr   = {24'($urandom), off[7:2], 2'($urandom)};
    wb_bus.dat_m = d;
    wb_bus.sel   = sel;
  endtask

  task automatic idle();
    wb_bus.cyc = 1'b0;
    wb_bus.stb = 1'b0;
    wb_bus.we  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    drive(1'b1, off, d, 4'hF);
    step();
    idle();
  endtask

  task automatic rd(input logic [7:0] off);
    drive(1'b0, off, 32'd0, 4'hF);
    step();
    idle();
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic read_all();
    for (int unsigned o = 0; o < 16 + 16 * NCH; o += 4) begin
      drive(1'b0, 8'(o), 32'd0, 4'hF);
      step();
    end
    idle();
    step();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit          prev, found, we;
    int unsigned nrise, last;
    logic [7:0]  o;
    logic [31:0] d;
    logic [3:0]  sel;

    idle();
    wb_bus.adr   = '0;
    wb_bus.dat_m = '0;
    wb_bus.sel   = '0;
    rst          = 1'b1;
    m_reset();
    run(3);
    rst = 1'b0;

    // Reset values on every mapped offset, back-to-back reads
    read_all();

    // Periodic channel 0, period (4+1)*(3+1)
    wr(8'h04, 32'd3);
    wr(8'h10, 32'd4);
    wr(8'h0C, 32'd1);
    wr(8'h18, 32'd3);
    wr(8'h00, 32'd1);
    prev = 0; nrise = 0; last = 0;
    for (int unsigned k = 0; k < 100; k++) begin
      if (irq) drive(1'b1, 8'h08, 32'd1, 4'hF);
      else     drive(1'b0, 8'h14, 32'd0, 4'hF);
      step();
      if (irq && !prev) begin
        if (nrise > 0) check("t2_period", cyc_no - last, 32'd20);
        last = cyc_no;
        nrise++;
      end
      prev = irq;
    end
    idle();
    check("t2_rises", 32'(nrise >= 4), 32'd1);
    wr(8'h18, 32'd0);
    wr(8'h08, 32'hF);

    // One-shot channel 1 with PRESC=0
    wr(8'h0C, 32'd2);
    wr(8'h04, 32'd0);
    wr(8'h20, 32'd2);
    wr(8'h28, 32'd1);
    prev = 0; nrise = 0;
    for (int unsigned k = 0; k < 20; k++) begin
      step();
      if (irq && !prev) nrise++;
      prev = irq;
    end
    check("t3_one_expiry", nrise, 32'd1);
    rd(8'h28);
    check("t3_ctrl_en", 32'(wb_bus.dat_s[0]), 32'd0);
    rd(8'h24);
    check("t3_count", wb_bus.dat_s, 32'd0);

    // Masking: only channel 1 reaches the outputs
    wr(8'h10, 32'd1);
    wr(8'h18, 32'd3);
    wr(8'h28, 32'd1);
    run(10);
    check("t4_irq_ch", 32'(irq_ch), 32'h2);
    check("t4_irq", 32'(irq), 32'd1);
    wr(8'h08, 32'd2);
    run(1);
    check("t4_irq_clr", 32'(irq), 32'd0);
    rd(8'h08);
    check("t4_stat0", 32'(wb_bus.dat_s[0]), 32'd1);

    // W1C of bit 0 on the exact edge channel 0 expires
    found = 0;
    for (int unsigned k = 0; k < 50 && !found; k++) begin
      if (m_gen && (m_pcnt == m_presc) && m_chen[0] && !m_pend[0] && (m_cnt[0] == 0)) begin
        drive(1'b1, 8'h08, 32'd1, 4'hF);
        step();
        idle();
        found = 1;
      end else begin
        step();
      end
    end
    check("t5_found", 32'(found), 32'd1);
    rd(8'h08);
    check("t5_set_wins", 32'(wb_bus.dat_s[0]), 32'd1);

    // Reset together with a request: no ack, everything cleared
    drive(1'b0, 8'h14, 32'd0, 4'hF);
    rst = 1'b1;
    step();
    check("t6_no_ack", 32'(wb_bus.ack), 32'd0);
    rst = 1'b0;
    idle();
    read_all();

    // Random traffic
    for (int unsigned k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1) == 1) begin
        o  = 8'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 19) * 4);
        we = 1'($urandom_range(0, 1));
        d  = $urandom;
        if (o == 8'h04)                       d = $urandom_range(0, 3);
        else if (o == 8'h00)                  d = 32'($urandom_range(0, 7) != 0);
        else if (o >= 8'h10 && o[3:0] == 4'h0) d = $urandom_range(0, 9);
        sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        drive(we, o, d, sel);
        wb_bus.cyc = ($urandom_range(0, 9) != 0);
      end else begin
        idle();
      end
      step();
    end
    idle();
    rst = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
